// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, vector locations, bubble and
// interrupt-sequence instruction encodings used by fetch and interruptHandler.
package cpu_pkg;

  typedef enum logic [2:0] {
    StRstHi,
    StRstLo,
    StRun,
    StIvtHi,
    StIvtLo
  } fetch_state_e;

  localparam logic [15:0] BUBBLE_INST    = 16'h07F8;
  localparam int unsigned RESET_VEC_ADDR = 0;
  localparam int unsigned IVT_ADDR       = 2;

  // Words injected by interruptHandler while entering a handler.
  localparam logic [15:0] IRQ_SAVE_PC_INST    = 16'hF480;
  localparam logic [15:0] IRQ_SAVE_FLAGS_INST = 16'hF481;

  // True while a two-word vector is being read instead of normal fetch.
  function automatic logic isVectorLoad(fetch_state_e s);
    return (s != StRun);
  endfunction

endpackage

// File: rtl/fetch_pc_controller_if.sv
// Fetch-stage bus: instruction memory, hazard/redirect inputs, IF/ID outputs.
// Optional pcFault appears when FETCH_PC_RANGE_CHECK_EN is defined.
interface fetch_pc_controller_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned INST_W = 16
);
  logic [ADDR_W-1:0] imemAddr;
  logic [INST_W-1:0] imemData;
  logic              stall;
  logic              branchTaken;
  logic [ADDR_W-1:0] branchTarget;
  logic              interruptRaisedInstruction;
  logic [INST_W-1:0] interruptInstruction;
  logic              interruptRaisedToFetch;
  logic [INST_W-1:0] fetchedInstruction;
  logic [ADDR_W-1:0] fetchedPC;
  logic              fetchValid;
  logic [ADDR_W-1:0] nextPC;
  logic              busy;
`ifdef FETCH_PC_RANGE_CHECK_EN
  logic              pcFault;
`endif

  // Fetch controller side.
  modport master (
`ifdef FETCH_PC_RANGE_CHECK_EN
    output pcFault,
`endif
    output imemAddr, fetchedInstruction, fetchedPC, fetchValid, nextPC, busy,
    input  imemData, stall, branchTaken, branchTarget, interruptRaisedInstruction,
    input  interruptInstruction, interruptRaisedToFetch
  );

  // Memory / pipeline / interrupt handler side.
  modport slave (
`ifdef FETCH_PC_RANGE_CHECK_EN
    input  pcFault,
`endif
    input  imemAddr, fetchedInstruction, fetchedPC, fetchValid, nextPC, busy,
    output imemData, stall, branchTaken, branchTarget, interruptRaisedInstruction,
    output interruptInstruction, interruptRaisedToFetch
  );
endinterface

// File: rtl/fetch_vector_loader.sv
// Two-word HI/LO vector sequencer shared by reset and interrupt entry.
// Owns the fetch state register; the top level reads the state to decide
// whether normal fetch is active.
module fetch_vector_loader
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned INST_W         = 16,
  parameter int unsigned RESET_VEC_ADDR = cpu_pkg::RESET_VEC_ADDR,
  parameter int unsigned IVT_ADDR       = cpu_pkg::IVT_ADDR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ivtReq,
  input  logic [INST_W-1:0] imemData,
  output fetch_state_e      state,
  output logic [ADDR_W-1:0] vecAddr,
  output logic              vecLoad,
  output logic [ADDR_W-1:0] vector,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] RstHiAddr = ADDR_W'(RESET_VEC_ADDR);
  localparam logic [ADDR_W-1:0] RstLoAddr = ADDR_W'(RESET_VEC_ADDR + 1);
  localparam logic [ADDR_W-1:0] IvtHiAddr = ADDR_W'(IVT_ADDR);
  localparam logic [ADDR_W-1:0] IvtLoAddr = ADDR_W'(IVT_ADDR + 1);

  fetch_state_e      state_q, state_d;
  logic [INST_W-1:0] vecHi_q;

  // Next state and vector read address; IVT requests only count in RUN.
  always_comb begin
    state_d = state_q;
    vecAddr = '0;
    vecLoad = 1'b0;
    case (state_q)
      StRstHi: begin vecAddr = RstHiAddr; state_d = StRstLo; end
      StRstLo: begin vecAddr = RstLoAddr; vecLoad = 1'b1; state_d = StRun; end
      StIvtHi: begin vecAddr = IvtHiAddr; state_d = StIvtLo; end
      StIvtLo: begin vecAddr = IvtLoAddr; vecLoad = 1'b1; state_d = StRun; end
      StRun:   if (ivtReq) state_d = StIvtHi;
      default: state_d = StRstHi;
    endcase
  end

  // State register and high-half capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StRstHi;
      vecHi_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StRstHi || state_q == StIvtHi) vecHi_q <= imemData;
    end
  end

  assign state  = state_q;
  assign vector = ADDR_W'({vecHi_q, imemData});
  assign busy   = isVectorLoad(state_q);

endmodule

// File: rtl/fetch_pc_controller.sv
// Fetch-stage PC controller and IF/ID source. Loads reset/IVT vectors,
// applies redirects, stalls and handler-injected words.
// Optional: FETCH_PC_RANGE_CHECK_EN adds IMEM_DEPTH and a sticky pcFault.
module fetch_pc_controller
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned INST_W         = 16,
  parameter int unsigned RESET_VEC_ADDR = cpu_pkg::RESET_VEC_ADDR,
  parameter int unsigned IVT_ADDR       = cpu_pkg::IVT_ADDR,
  parameter logic [INST_W-1:0] BUBBLE_INST = INST_W'(cpu_pkg::BUBBLE_INST)
`ifdef FETCH_PC_RANGE_CHECK_EN
  ,
  parameter int unsigned IMEM_DEPTH = 2 ** 20
`endif
) (
  input logic                   clk,
  input logic                   reset,
  fetch_pc_controller_if.master bus
);

  fetch_state_e      state;
  logic [ADDR_W-1:0] vecAddr;
  logic              vecLoad;
  logic [ADDR_W-1:0] vector;
  logic              pcOutOfRange;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [ADDR_W-1:0] fpc_q, fpc_d;
  logic              valid_q, valid_d;

  fetch_vector_loader #(
    .ADDR_W        (ADDR_W),
    .INST_W        (INST_W),
    .RESET_VEC_ADDR(RESET_VEC_ADDR),
    .IVT_ADDR      (IVT_ADDR)
  ) u_loader (
    .clk     (clk),
    .reset   (reset),
    .ivtReq  (bus.interruptRaisedToFetch),
    .imemData(bus.imemData),
    .state   (state),
    .vecAddr (vecAddr),
    .vecLoad (vecLoad),
    .vector  (vector),
    .busy    (bus.busy)
  );

`ifdef FETCH_PC_RANGE_CHECK_EN
  logic fault_q;

  assign pcOutOfRange = (state == StRun) &&
                        ({1'b0, pc_q} >= (ADDR_W + 1)'(IMEM_DEPTH));

  // Sticky fault: only reset clears it, redirects leave it set.
  always_ff @(posedge clk) begin
    if (reset)             fault_q <= 1'b0;
    else if (pcOutOfRange) fault_q <= 1'b1;
  end

  assign bus.pcFault = fault_q;
`else
  assign pcOutOfRange = 1'b0;
`endif

  // PC priority mux and IF/ID next value.
  always_comb begin
    pc_d    = pc_q;
    inst_d  = inst_q;
    fpc_d   = fpc_q;
    valid_d = valid_q;
    if (state != StRun) begin
      // Vector load: stall/branch ignored, pipeline fed bubbles.
      inst_d  = BUBBLE_INST;
      valid_d = 1'b0;
      if (vecLoad) pc_d = vector;
    end else if (bus.interruptRaisedToFetch) begin
      inst_d  = BUBBLE_INST;
      valid_d = 1'b0;
    end else if (bus.branchTaken) begin
      pc_d    = bus.branchTarget;
      inst_d  = BUBBLE_INST;
      valid_d = 1'b0;
    end else if (pcOutOfRange) begin
      inst_d  = BUBBLE_INST;
      valid_d = 1'b0;
    end else if (bus.stall) begin
      // Hold everything.
    end else if (bus.interruptRaisedInstruction) begin
      inst_d  = bus.interruptInstruction;
      fpc_d   = pc_q;
      valid_d = 1'b0;
    end else begin
      inst_d  = bus.imemData;
      fpc_d   = pc_q;
      valid_d = 1'b1;
      pc_d    = pc_q + ADDR_W'(1);
    end
  end

  // PC and IF/ID registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= '0;
      inst_q  <= BUBBLE_INST;
      fpc_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      fpc_q   <= fpc_d;
      valid_q <= valid_d;
    end
  end

  assign bus.imemAddr           = (state == StRun) ? pc_q : vecAddr;
  assign bus.nextPC             = pc_q + ADDR_W'(1);
  assign bus.fetchedInstruction = inst_q;
  assign bus.fetchedPC          = fpc_q;
  assign bus.fetchValid         = valid_q;

endmodule

// File: tb/tb_fetch_pc_controller.sv
// Bench for fetch_pc_controller: directed scenarios plus a randomized run
// compared against a cycle-level behavioural model.
module tb_fetch_pc_controller;

  localparam logic [15:0] Bubble = 16'h07F8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_pc_controller_if #(.ADDR_W(32), .INST_W(16)) ifc ();

  fetch_pc_controller dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ifc)
  );

  logic [15:0] mem [4096];
  assign ifc.imemData = mem[ifc.imemAddr[11:0]];

  int passed = 0;
  int total  = 0;

  // Model: cycles left in a vector load, vector base, PC and IF/ID contents.
  int          mLoad;
  logic [31:0] mBase;
  logic [31:0] mPc;
  logic [31:0] mFpc;
  logic [15:0] mInst;
  logic        mValid;

  // Apply one cycle of inputs, advance the model, then wait past the edge.
  task automatic step(input logic rst, input logic st, input logic br,
                      input logic [31:0] tgt, input logic inj,
                      input logic [15:0] ins, input logic irq);
    logic [11:0] a;
    reset                          = rst;
    ifc.stall                      = st;
    ifc.branchTaken                = br;
    ifc.branchTarget               = tgt;
    ifc.interruptRaisedInstruction = inj;
    ifc.interruptInstruction       = ins;
    ifc.interruptRaisedToFetch     = irq;
    if (rst) begin
      mLoad = 2; mBase = 32'd0; mPc = 32'd0;
      mInst = Bubble; mFpc = 32'd0; mValid = 1'b0;
    end else if (mLoad > 0) begin
      mInst = Bubble; mValid = 1'b0;
      if (mLoad == 1) begin
        a   = mBase[11:0];
        mPc = {mem[a], mem[a + 12'd1]};
      end
      mLoad = mLoad - 1;
    end else if (irq) begin
      mLoad = 2; mBase = 32'd2; mInst = Bubble; mValid = 1'b0;
    end else if (br) begin
      mPc = tgt; mInst = Bubble; mValid = 1'b0;
    end else if (st) begin
      // held
    end else if (inj) begin
      mInst = ins; mFpc = mPc; mValid = 1'b0;
    end else begin
      mInst = mem[mPc[11:0]]; mFpc = mPc; mValid = 1'b1; mPc = mPc + 32'd1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 16'd0, 1'b0);
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 16'd0, 1'b0);
    total++;
    if ({ifc.fetchedInstruction, ifc.fetchedPC, ifc.fetchValid, ifc.busy} !==
        {Bubble, 32'd0, 1'b0, 1'b1})
      $display("FAIL reset_state: got inst=%h pc=%h v=%b busy=%b want %h 0 0 1",
               ifc.fetchedInstruction, ifc.fetchedPC, ifc.fetchValid, ifc.busy, Bubble);
    else passed++;
    idle();
    total++;
    if (ifc.busy !== 1'b1) $display("FAIL reset_busy2: got %b want 1", ifc.busy);
    else passed++;
    idle();
    total++;
    if ({ifc.busy, ifc.nextPC} !== {1'b0, 32'h11})
      $display("FAIL reset_loaded: got busy=%b nextPC=%h want 0 00000011",
               ifc.busy, ifc.nextPC);
    else passed++;
  endtask

  task automatic test_sequential();
    logic [15:0] exp [3];
    exp[0] = 16'h1111; exp[1] = 16'h2222; exp[2] = 16'h3333;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (ifc.nextPC !== 32'h11 + 32'(i))
        $display("FAIL seq_nextpc%0d: got %h want %h", i, ifc.nextPC, 32'h11 + 32'(i));
      else passed++;
      idle();
      total++;
      if ({ifc.fetchedInstruction, ifc.fetchedPC, ifc.fetchValid} !==
          {exp[i], 32'h10 + 32'(i), 1'b1})
        $display("FAIL seq_fetch%0d: got %h@%h v=%b want %h@%h v=1", i,
                 ifc.fetchedInstruction, ifc.fetchedPC, ifc.fetchValid,
                 exp[i], 32'h10 + 32'(i));
      else passed++;
    end
  endtask

  task automatic test_stall_branch();
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 16'd0, 1'b0);
      total++;
      if ({ifc.fetchedInstruction, ifc.fetchedPC, ifc.fetchValid, ifc.nextPC} !==
          {16'h3333, 32'h12, 1'b1, 32'h14})
        $display("FAIL stall_hold%0d: got %h@%h v=%b next=%h want 3333@12 v=1 next=14",
                 i, ifc.fetchedInstruction, ifc.fetchedPC, ifc.fetchValid, ifc.nextPC);
      else passed++;
    end
    step(1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 16'd0, 1'b0);
    total++;
    if ({ifc.fetchedInstruction, ifc.fetchValid, ifc.nextPC} !== {Bubble, 1'b0, 32'h41})
      $display("FAIL branch_bubble: got %h v=%b next=%h want %h v=0 next=41",
               ifc.fetchedInstruction, ifc.fetchValid, ifc.nextPC, Bubble);
    else passed++;
    idle();
    total++;
    if ({ifc.fetchedInstruction, ifc.fetchedPC, ifc.fetchValid} !==
        {mem[12'h40], 32'h40, 1'b1})
      $display("FAIL branch_target: got %h@%h v=%b want %h@40 v=1",
               ifc.fetchedInstruction, ifc.fetchedPC, ifc.fetchValid, mem[12'h40]);
    else passed++;
  endtask

  task automatic test_injection();
    step(1'b0, 1'b0, 1'b1, 32'h20, 1'b0, 16'd0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 16'hF480, 1'b0);
    total++;
    if ({ifc.fetchedInstruction, ifc.fetchedPC, ifc.fetchValid, ifc.nextPC} !==
        {16'hF480, 32'h20, 1'b0, 32'h21})
      $display("FAIL inject: got %h@%h v=%b next=%h want f480@20 v=0 next=21",
               ifc.fetchedInstruction, ifc.fetchedPC, ifc.fetchValid, ifc.nextPC);
    else passed++;
    idle();
    total++;
    if ({ifc.fetchedInstruction, ifc.fetchedPC, ifc.fetchValid} !==
        {mem[12'h20], 32'h20, 1'b1})
      $display("FAIL inject_resume: got %h@%h v=%b want %h@20 v=1",
               ifc.fetchedInstruction, ifc.fetchedPC, ifc.fetchValid, mem[12'h20]);
    else passed++;
  endtask

  task automatic test_ivt();
    step(1'b0, 1'b0, 1'b1, 32'h55, 1'b0, 16'd0, 1'b1);
    total++;
    if ({ifc.fetchedInstruction, ifc.fetchValid, ifc.busy} !== {Bubble, 1'b0, 1'b1})
      $display("FAIL ivt_enter: got %h v=%b busy=%b want %h 0 1",
               ifc.fetchedInstruction, ifc.fetchValid, ifc.busy, Bubble);
    else passed++;
    // Re-request during load must not restart it.
    step(1'b0, 1'b1, 1'b1, 32'h66, 1'b0, 16'd0, 1'b1);
    total++;
    if ({ifc.fetchedInstruction, ifc.busy} !== {Bubble, 1'b1})
      $display("FAIL ivt_hi: got %h busy=%b want %h 1", ifc.fetchedInstruction,
               ifc.busy, Bubble);
    else passed++;
    idle();
    total++;
    if ({ifc.fetchedInstruction, ifc.busy, ifc.nextPC} !== {Bubble, 1'b0, 32'h101})
      $display("FAIL ivt_lo: got %h busy=%b next=%h want %h 0 101",
               ifc.fetchedInstruction, ifc.busy, ifc.nextPC, Bubble);
    else passed++;
    idle();
    total++;
    if ({ifc.fetchedInstruction, ifc.fetchedPC, ifc.fetchValid} !==
        {16'hBEEF, 32'h100, 1'b1})
      $display("FAIL ivt_target: got %h@%h v=%b want beef@100 v=1",
               ifc.fetchedInstruction, ifc.fetchedPC, ifc.fetchValid);
    else passed++;
  endtask

  task automatic test_reset_mid_ivt();
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 16'd0, 1'b1);
    idle();
    total++;
    if (ifc.busy !== 1'b1) $display("FAIL midivt_busy: got %b want 1", ifc.busy);
    else passed++;
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 16'd0, 1'b0);
    idle();
    idle();
    total++;
    if ({ifc.busy, ifc.nextPC} !== {1'b0, 32'h11})
      $display("FAIL midivt_reload: got busy=%b next=%h want 0 11", ifc.busy, ifc.nextPC);
    else passed++;
    idle();
    total++;
    if ({ifc.fetchedPC, ifc.fetchValid} !== {32'h10, 1'b1})
      $display("FAIL midivt_fetch: got %h v=%b want 10 v=1", ifc.fetchedPC, ifc.fetchValid);
    else passed++;
  endtask

  task automatic test_wrap();
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 16'd0, 1'b0);
    total++;
    if (ifc.nextPC !== 32'd0) $display("FAIL wrap_next: got %h want 0", ifc.nextPC);
    else passed++;
    idle();
    total++;
    if ({ifc.fetchedPC, ifc.fetchValid, ifc.nextPC} !== {32'hFFFF_FFFF, 1'b1, 32'd1})
      $display("FAIL wrap_fetch: got %h v=%b next=%h want ffffffff 1 1",
               ifc.fetchedPC, ifc.fetchValid, ifc.nextPC);
    else passed++;
  endtask

  task automatic test_random();
    logic rst, st, br, inj, irq;
    logic [31:0] tgt;
    logic [15:0] ins;
    for (int i = 4; i < 4096; i++) mem[i] = 16'($urandom);
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 16'd0, 1'b0);
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(63) == 0);
      irq = ($urandom_range(15) == 0);
      br  = ($urandom_range(7) == 0);
      st  = ($urandom_range(3) == 0);
      inj = ($urandom_range(5) == 0);
      tgt = 32'($urandom_range(4000));
      ins = 16'($urandom);
      step(rst, st, br, tgt, inj, ins, irq);
      total++;
      if ({ifc.fetchedInstruction, ifc.fetchedPC, ifc.fetchValid, ifc.busy, ifc.nextPC} !==
          {mInst, mFpc, mValid, (mLoad != 0), mPc + 32'd1})
        $display("FAIL random%0d: got %h@%h v=%b busy=%b next=%h want %h@%h v=%b busy=%b next=%h",
                 n, ifc.fetchedInstruction, ifc.fetchedPC, ifc.fetchValid, ifc.busy,
                 ifc.nextPC, mInst, mFpc, mValid, (mLoad != 0), mPc + 32'd1);
      else passed++;
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 16'(i) ^ 16'h5A5A;
    mem[0] = 16'h0000; mem[1] = 16'h0010;
    mem[2] = 16'h0000; mem[3] = 16'h0100;
    mem[12'h10] = 16'h1111; mem[12'h11] = 16'h2222; mem[12'h12] = 16'h3333;
    mem[12'h100] = 16'hBEEF;
    reset = 1'b1;
    ifc.stall = 1'b0; ifc.branchTaken = 1'b0; ifc.branchTarget = '0;
    ifc.interruptRaisedInstruction = 1'b0; ifc.interruptInstruction = '0;
    ifc.interruptRaisedToFetch = 1'b0;
    #2;
    test_reset();
    test_sequential();
    test_stall_branch();
    test_injection();
    test_ivt();
    test_reset_mid_ivt();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
